switch_debouncer: RTL
=====================

// Module: switch_debouncer
//
// PURPOSE
//   Input-side conditioner for the board slide switches/buttons.
//   Synchronises N raw asynchronous switch inputs into i_clk, debounces each bit independently,
//   and outputs clean stable levels plus one-cycle rise/fall pulses.
//   Sits between the switch pins and any logic that reads them, including the LED drivers.
//
// PARAMETERS
//   N                2       number of switch bits; the bench uses 4
//   DEBOUNCE_CYCLES  250000  consecutive clocks of disagreement required before a bit flips
//                            (10 ms at 25 MHz); legal range >= 2
//   CNT_W            localparam = $clog2(DEBOUNCE_CYCLES); per-bit counter width
//
// PORTS
//   i_clk     in   1  system clock; all logic on the rising edge
//   i_rst_n   in   1  synchronous reset, active-low
//   i_switch  in   N  raw asynchronous switch levels
//   o_switch  out  N  debounced stable level per bit
//   o_rise    out  N  one-cycle pulse per bit: stable level went 0->1
//   o_fall    out  N  one-cycle pulse per bit: stable level went 1->0
//   o_change  out  1  one-cycle pulse: OR of o_rise|o_fall, same cycle
//
// BEHAVIOUR
// - Reset: while i_rst_n=0 at a rising edge, everything clears to 0 on that edge:
//   sync flops, counters, o_switch, o_rise, o_fall and o_change.
// - Reset mid-count discards the partial count, so no pulse is produced.
// - Sync: two flops per bit, i_switch -> s1 -> s2. Only s2 feeds the debounce logic.
// - Per bit, on every edge (reset released):
//   - s2 == o_switch: counter <= 0. A glitch shorter than DEBOUNCE_CYCLES is rejected.
//   - s2 != o_switch and counter == DEBOUNCE_CYCLES-1:
//     o_switch <= s2; counter <= 0; o_rise or o_fall (by direction) <= 1.
//   - s2 != o_switch otherwise: counter <= counter+1.
// - Pulses are registered and high for exactly one cycle, on the same edge o_switch updates.
//   They deassert on the next edge.
// - Latency: i_switch changes between edges and then holds. Counting the first sampling edge
//   as edge 1, o_switch and the pulse update on edge DEBOUNCE_CYCLES+2 (edge 6 for D=4).
// - Bounce: any return of s2 to o_switch restarts the count from 0. A settled bouncing input
//   gives exactly one pulse, D+2 edges after its final transition.
// - Bits are independent. Simultaneous changes on several bits in opposite directions assert
//   o_rise and o_fall bits in the same cycle.
// - Counter never wraps: it is bounded at DEBOUNCE_CYCLES-1 by the update rule.
// - Power-up: o_switch resets to 0. A switch held high through reset release therefore yields
//   an o_rise pulse D+2 edges after release. This is intended.
//
// STRUCTURE
// - Shared package switches_pkg holds:
//   - the default debounce constant: DEBOUNCE_10MS_25MHZ = 250000
//   - the bench constant: DEBOUNCE_SIM = 4
//   - function cnt_width(d) = $clog2(d)
// - Sub-module switch_debounce_bit (one bit: sync pair, counter, stable flop, rise/fall flops)
//   is instantiated N times in a generate loop.
// - Top level only concatenates the per-bit outputs and ORs them into o_change.
//
// TESTING  (N=4, DEBOUNCE_CYCLES=4, i_switch changed mid-cycle, edges counted from the
//           first sampling edge)
// 1. Reset: i_switch=4'hF, i_rst_n=0 for 3 edges -> all outputs 0.
//    Release -> o_switch=4'hF and o_rise=4'hF on edge 6 only; o_change=1 on edge 6 only.
// 2. Glitch: i_switch[0]=1 for 3 cycles, then 0 -> o_switch stays 4'h0; o_rise and o_fall
//    never assert.
// 3. Clean press/release: i_switch=4'b0100 held 20 cycles -> o_switch[2]=1 and o_rise=4'b0100
//    on edge 6. Then i_switch=0 -> o_fall=4'b0100 on edge 6 after release.
// 4. Bounce: i_switch[1] toggles every cycle for 5 cycles, then holds 1 -> exactly one o_rise
//    pulse (4'b0010), 6 edges after the final transition.
// 5. Simultaneous: from o_switch=4'b1000, set i_switch=4'b0001 -> on the same edge
//    o_rise=4'b0001, o_fall=4'b1000, o_change=1.
// 6. Reset mid-count: i_switch=4'h3, pull i_rst_n low on edge 4 for one cycle, then hold the
//    input -> no pulse before the new count completes; o_rise=4'h3 on edge 6 after release.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// Shared constants and helpers for the switch input conditioner.
// Holds the production and simulation debounce lengths plus the counter-width helper.
package switches_pkg;

  localparam int DEBOUNCE_10MS_25MHZ = 250000;
  localparam int DEBOUNCE_SIM        = 4;

  function automatic int cnt_width(input int d);
    return $clog2(d);
  endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch bus: raw levels in, debounced levels and edge pulses out.
// Valid/ready does not apply: every signal is a level or a one-cycle pulse sampled on i_clk.
interface switch_debouncer_if #(
  parameter int N = 2
);

  logic [N-1:0] i_switch;
  logic [N-1:0] o_switch;
  logic [N-1:0] o_rise;
  logic [N-1:0] o_fall;
  logic         o_change;

  // master sits on the pin side, slave is the debouncer
  modport master (
    output i_switch,
    input  o_switch, o_rise, o_fall, o_change
  );

  modport slave (
    input  i_switch,
    output o_switch, o_rise, o_fall, o_change
  );

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser, disagreement counter, stable level and edge pulses.
// The stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module switch_debounce_bit
  import switches_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      // any agreeing sample restarts the count, so bounces never accumulate
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
        rise   <= s2;
        fall   <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// N-bit switch conditioner: one independent debounce slice per bit.
// The top only gathers per-bit outputs and ORs the pulses into o_change.
module switch_debouncer
  import switches_pkg::*;
#(
  parameter int N               = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  switch_debouncer_if.slave    bus
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [N-1:0] stable_q;
  logic [N-1:0] rise_q;
  logic [N-1:0] fall_q;

  for (genvar b = 0; b < N; b++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .raw    (bus.i_switch[b]),
      .stable (stable_q[b]),
      .rise   (rise_q[b]),
      .fall   (fall_q[b])
    );
  end

  assign bus.o_switch = stable_q;
  assign bus.o_rise   = rise_q;
  assign bus.o_fall   = fall_q;
  assign bus.o_change = |(rise_q | fall_q);

endmodule
